// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, canonical NOP and base opcodes
// used by the fetch queue and by ID control decode.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Base opcode field values (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/if_id_queue.sv
// Instruction prefetch queue between IF and ID. Buffers up to DEPTH {pc, instr}
// pairs, presents the oldest first-word-fall-through, and discards everything
// on a taken branch (flush), keeping a saturating tally of discarded entries.
// Ports:
//   clk, res                  clock, async active-low reset
//   in_valid/in_pc/in_instr   push side from IF; in_ready = not full
//   out_valid/out_pc/out_instr head entry to ID (NOP / pc 0 when empty)
//   out_ready                 ID consumes head
//   flush                     taken branch from EX, wins over push and pop
//   count                     occupancy 0..DEPTH
//   drop_cnt                  saturating count of flushed entries
module if_id_queue #(
    parameter  int unsigned XLEN  = riscv_pkg::XLEN,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      drop_cnt
);
    import riscv_pkg::*;

    localparam int unsigned ENT_W = 2 * XLEN;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [16:0]      drop_sum;
    logic             full, empty, push, pop;
    logic [ENT_W-1:0] head;

    // Full/empty derive from occupancy only; pointers are free-running mod DEPTH
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        push  = in_valid & ~full & ~flush;
        pop   = ~empty & out_ready & ~flush;
    end

    // Next-state for pointers, occupancy and drop counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(count_q);
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
    end

    // Head presentation: empty queue shows a NOP at pc 0
    always_comb begin
        head      = mem_q[rd_ptr_q];
        in_ready  = ~full;
        out_valid = ~empty;
        count     = count_q;
        drop_cnt  = drop_cnt_q;
        if (empty) begin
            out_pc    = '0;
            out_instr = XLEN'(NOP_INSTR);
        end else begin
            out_pc    = head[ENT_W-1:XLEN];
            out_instr = head[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based scoreboard of expected
// head entries and a model of occupancy and drop count.
module tb_if_id_queue;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        res;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;
    logic [15:0] drop_cnt;

    ent_t        sb[$];
    int unsigned drop_m;
    int          checks;
    int          errors;

    if_id_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .res      (res),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .flush    (flush),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = 32'hA500_0000 ^ (pc << 4) ^ 32'h0000_0093;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Check current outputs against the model, advance the model, take one edge
    task automatic cycle(input string tag);
        logic push;
        logic pop;
        ent_t head;
        ent_t dummy;
        chk({tag, ":count"},     64'(count),     64'(sb.size()));
        chk({tag, ":in_ready"},  64'(in_ready),  64'(sb.size() != DEPTH));
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
        chk({tag, ":drop_cnt"},  64'(drop_cnt),  64'(drop_m));
        if (sb.size() != 0) begin
            head = sb[0];
            chk({tag, ":out_pc"},    64'(out_pc),    64'(head.pc));
            chk({tag, ":out_instr"}, 64'(out_instr), 64'(head.instr));
        end else begin
            chk({tag, ":out_pc_empty"},    64'(out_pc),    64'(0));
            chk({tag, ":out_instr_empty"}, 64'(out_instr), 64'(NOP_INSTR));
        end
        push = in_valid && (sb.size() != DEPTH) && !flush;
        pop  = out_ready && (sb.size() != 0) && !flush;
        if (flush) begin
            drop_m = drop_m + sb.size();
            if (drop_m > 32'hFFFF) drop_m = 32'hFFFF;
            sb.delete();
        end else begin
            if (pop)  dummy = sb.pop_front();
            if (push) sb.push_back('{pc: in_pc, instr: in_instr});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drop_m = 0;
        res    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        #3;
        chk("rst:count",     64'(count),     64'(0));
        chk("rst:out_valid", 64'(out_valid), 64'(0));
        chk("rst:in_ready",  64'(in_ready),  64'(1));
        chk("rst:out_instr", 64'(out_instr), 64'(NOP_INSTR));
        chk("rst:out_pc",    64'(out_pc),    64'(0));
        chk("rst:drop_cnt",  64'(drop_cnt),  64'(0));
        @(posedge clk);
        #1;
        res = 1'b1;

        // Fill with ID stalled, then a refused fifth push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            cycle("fill");
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        cycle("full_refuse");
        chk("full:count",    64'(count),    64'(DEPTH));
        chk("full:in_ready", 64'(in_ready), 64'(0));
        chk("full:out_pc",   64'(out_pc),   64'(0));

        // Drain in order; first drain cycle also offers a push that full must refuse
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        cycle("drain_full");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle("drain");
        end
        chk("drained:out_valid", 64'(out_valid), 64'(0));

        // Streaming across pointer wrap
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive(1'b1, 32'(32'h100 + i * 4), 1'b1, 1'b0);
            if (i > 0) chk("stream:steady_count", 64'(count), 64'(1));
            cycle("stream");
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle("stream_tail");
        cycle("stream_empty");

        // Flush with three entries and a concurrent push/pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h20 + i * 4), 1'b0, 1'b0);
            cycle("pre_flush");
        end
        drive(1'b1, 32'h30, 1'b1, 1'b1);
        cycle("flush");
        chk("flush:count",     64'(count),     64'(0));
        chk("flush:drop_cnt",  64'(drop_cnt),  64'(3));
        chk("flush:out_valid", 64'(out_valid), 64'(0));
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        cycle("post_flush_push");
        chk("post_flush:out_pc", 64'(out_pc), 64'(32'h40));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle("post_flush_pop");

        // Async reset between edges
        drive(1'b1, 32'h60, 1'b0, 1'b0);
        cycle("pre_rst");
        drive(1'b1, 32'h64, 1'b0, 1'b0);
        cycle("pre_rst");
        chk("pre_rst:count", 64'(count), 64'(2));
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        res = 1'b0;
        #1;
        chk("async_rst:count",     64'(count),     64'(0));
        chk("async_rst:out_valid", 64'(out_valid), 64'(0));
        chk("async_rst:drop_cnt",  64'(drop_cnt),  64'(0));
        sb.delete();
        drop_m = 0;
        #1;
        res = 1'b1;
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        cycle("post_rst_push");
        chk("post_rst:out_pc", 64'(out_pc), 64'(32'h80));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle("post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
